// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package reg_file_pkg;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 5;
    localparam int RF_NREAD = 2;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-address forcing, write-through bypass,
// and pending-flag masking.
module rf_read_port #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             run,
    input  logic [DEPTH-1:0] addr,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             pending,
    input  logic             wr,
    input  logic [DEPTH-1:0] write_register,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] data,
    output logic             busy
);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (!run) begin
            // Contents are being swept; report every register as not yet valid.
            busy = 1'b1;
        end else if (addr != '0) begin
            if (wr && (write_register == addr)) begin
                data = write_data;
            end else begin
                data = reg_data;
                busy = pending;
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with a pending-write scoreboard and a power-up /
// soft-clear sweep that zeroes one register per clock.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NREAD = RF_NREAD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_req,
    output logic                   ready,
    input  logic                   wr,
    input  logic [DEPTH-1:0]       write_register,
    input  logic [WIDTH-1:0]       write_data,
    input  logic [NREAD*DEPTH-1:0] read_register,
    output logic [NREAD*WIDTH-1:0] read_data,
    input  logic                   issue,
    input  logic [DEPTH-1:0]       issue_register,
    output logic [NREAD-1:0]       read_busy,
    output rf_state_t              state_dbg
);

    localparam int               NREGS    = 2 ** DEPTH;
    localparam logic [DEPTH-1:0] LAST_IDX = '1;
    localparam logic [DEPTH-1:0] ONE      = DEPTH'(1);

    rf_state_t        state;
    logic [DEPTH-1:0] cnt;
    logic [NREGS-1:0] pending;
    logic [WIDTH-1:0] regs [NREGS];

    logic run;
    logic do_write;
    logic do_issue;

    // ready: wr and issue take effect only on edges where ready is high;
    // while it is low they are dropped and read ports are masked.
    assign run       = (state == RF_RUN);
    assign do_write  = run && wr && (write_register != '0);
    assign do_issue  = run && issue && (issue_register != '0);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RF_INIT;
            cnt     <= ONE;
            ready   <= 1'b0;
            pending <= '0;
        end else begin
            case (state)
                RF_INIT: begin
                    pending[cnt] <= 1'b0;
                    cnt          <= cnt + ONE;
                    if (cnt == LAST_IDX) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    // Issue is applied last so a same-edge issue keeps the register pending.
                    if (do_write) pending[write_register] <= 1'b0;
                    if (do_issue) pending[issue_register] <= 1'b1;
                end
                default: begin
                    state <= RF_INIT;
                    cnt   <= ONE;
                    ready <= 1'b0;
                end
            endcase
            if (init_req) begin
                state <= RF_INIT;
                cnt   <= ONE;
                ready <= 1'b0;
            end
        end
    end

    // Storage has no reset; the sweep clears it. Register 0 is never read back.
    always_ff @(posedge clk) begin
        if (state == RF_INIT) begin
            regs[cnt] <= '0;
        end else if (do_write) begin
            regs[write_register] <= write_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [DEPTH-1:0] addr;
        assign addr = read_register[i*DEPTH +: DEPTH];

        rf_read_port #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_port (
            .run           (run),
            .addr          (addr),
            .reg_data      (regs[addr]),
            .pending       (pending[addr]),
            .wr            (wr),
            .write_register(write_register),
            .write_data    (write_data),
            .data          (read_data[i*WIDTH +: WIDTH]),
            .busy          (read_busy[i])
        );
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a random phase,
// read data scored through an expected queue against a small behavioural model.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int W  = 32;
    localparam int D  = 5;
    localparam int N  = 2;
    localparam int NR = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           init_req;
    logic           ready;
    logic           wr;
    logic [D-1:0]   write_register;
    logic [W-1:0]   write_data;
    logic [N*D-1:0] read_register;
    logic [N*W-1:0] read_data;
    logic           issue;
    logic [D-1:0]   issue_register;
    logic [N-1:0]   read_busy;
    rf_state_t      state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0]  m_regs [NR];
    logic [NR-1:0] m_pend;
    logic          m_run;
    int            m_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    reg_file_sb #(.WIDTH(W), .DEPTH(D), .NREAD(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_req      (init_req),
        .ready         (ready),
        .wr            (wr),
        .write_register(write_register),
        .write_data    (write_data),
        .read_register (read_register),
        .read_data     (read_data),
        .issue         (issue),
        .issue_register(issue_register),
        .read_busy     (read_busy),
        .state_dbg     (state_dbg)
    );

    // ---------------- model ----------------
    function automatic logic [W-1:0] exp_data(input logic [D-1:0] a);
        if (!m_run || a == '0) return '0;
        if (wr && write_register == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [D-1:0] a);
        if (!m_run) return 1'b1;
        if (a == '0) return 1'b0;
        if (wr && write_register == a) return 1'b0;
        return m_pend[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic old_run;
        old_run = m_run;
        if (rst) begin
            m_run = 1'b0; m_cnt = 1; m_pend = '0;
        end else begin
            if (old_run) begin
                if (wr && write_register != '0) begin
                    m_regs[write_register] = write_data;
                    m_pend[write_register] = 1'b0;
                end
                if (issue && issue_register != '0) m_pend[issue_register] = 1'b1;
            end
            if (init_req) begin
                m_run = 1'b0; m_cnt = 1;
            end else if (!old_run) begin
                m_regs[m_cnt] = '0;
                m_pend[m_cnt] = 1'b0;
                if (m_cnt == NR - 1) m_run = 1'b1;
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reads(input logic [D-1:0] a0, input logic [D-1:0] a1);
        read_register = {a1, a0};
        exp_q.push_back(exp_data(a0));
        exp_q.push_back(exp_data(a1));
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_pop(input string name);
        logic [W-1:0] e;
        #1;
        for (int p = 0; p < N; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (read_data[p*W +: W] !== e) begin
                errors++;
                $display("FAIL %s port%0d: got %h expected %h", name, p, read_data[p*W +: W], e);
            end
        end
    endtask

    task automatic idle_inputs();
        init_req = 0; wr = 0; issue = 0;
        write_register = '0; write_data = '0; issue_register = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        read_register = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_run = 1'b0; m_cnt = 1; m_pend = '0;
        #12;
        checks++;
        if (ready !== 1'b0 || state_dbg !== RF_INIT) begin
            errors++;
            $display("FAIL reset_state: ready=%b state=%0d expected ready=0 state=RF_INIT", ready, state_dbg);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (ready !== (i == 31)) begin
                errors++;
                $display("FAIL reset_ready edge %0d: ready=%b expected %b", i, ready, (i == 31));
            end
        end
        for (int a = 0; a < NR; a += 2) begin
            drive_reads(D'(a), D'(a + 1));
            sb_pop("reset_zero");
        end
        checks++;
        if (read_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 00", read_busy);
        end
    endtask

    task automatic test_bypass();
        wr = 1; write_register = 5; write_data = 32'hDEADBEEF;
        drive_reads(5, 0);
        sb_pop("bypass_same_cycle");
        checks++;
        if (read_data[W-1:0] !== 32'hDEADBEEF || read_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_const: data=%h busy=%b expected deadbeef/0", read_data[W-1:0], read_busy[0]);
        end
        tick();
        wr = 0;
        drive_reads(5, 5);
        sb_pop("r5_after_write");
    endtask

    task automatic test_r0();
        wr = 1; write_register = 0; write_data = 32'h12345678;
        tick();
        wr = 0;
        drive_reads(0, 0);
        sb_pop("r0_reads_zero");
        checks++;
        if (read_data !== '0 || read_busy !== 2'b00) begin
            errors++;
            $display("FAIL r0_const: data=%h busy=%b expected 0/00", read_data, read_busy);
        end
    endtask

    task automatic test_busy();
        issue = 1; issue_register = 7;
        tick();
        issue = 0;
        drive_reads(7, 0);
        sb_pop("busy_issue_data");
        checks++;
        if (read_busy !== 2'b01) begin
            errors++;
            $display("FAIL busy_after_issue: got %b expected 01", read_busy);
        end
        wr = 1; write_register = 7; write_data = 32'h55;
        drive_reads(7, 7);
        sb_pop("busy_write_bypass");
        checks++;
        if (read_busy !== 2'b00) begin
            errors++;
            $display("FAIL busy_write_cycle: got %b expected 00", read_busy);
        end
        tick();
        wr = 0;
        drive_reads(7, 7);
        sb_pop("busy_after_write");
        checks++;
        if (read_busy !== 2'b00) begin
            errors++;
            $display("FAIL busy_cleared: got %b expected 00", read_busy);
        end
        wr = 1; write_data = 32'h66; issue = 1; issue_register = 7;
        tick();
        wr = 0; issue = 0;
        drive_reads(7, 7);
        sb_pop("issue_and_write_data");
        checks++;
        if (read_busy !== 2'b11) begin
            errors++;
            $display("FAIL issue_wins: got %b expected 11", read_busy);
        end
    endtask

    task automatic test_init_req();
        wr = 1; write_register = 3; write_data = 32'hA5;
        tick();
        wr = 0;
        drive_reads(3, 3);
        sb_pop("r3_before_init");
        init_req = 1;
        tick();
        init_req = 0;
        wr = 1; write_register = 3; write_data = 32'hFFFF_FFFF;
        issue = 1; issue_register = 3;
        for (int i = 1; i <= 31; i++) begin
            checks++;
            if (ready !== 1'b0 || read_busy !== 2'b11) begin
                errors++;
                $display("FAIL init_sweep %0d: ready=%b busy=%b expected 0/11", i, ready, read_busy);
            end
            drive_reads(3, 0);
            sb_pop("init_sweep_zero");
            tick();
        end
        idle_inputs();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready: got %b expected 1", ready);
        end
        drive_reads(3, 3);
        sb_pop("r3_after_init");
        checks++;
        if (read_busy !== 2'b00) begin
            errors++;
            $display("FAIL init_busy: got %b expected 00", read_busy);
        end
    endtask

    task automatic test_async_rst();
        wr = 1; write_register = 9; write_data = 32'hCAFE_0009;
        #2;
        rst = 1;
        m_run = 1'b0; m_cnt = 1; m_pend = '0;
        #1;
        checks++;
        if (ready !== 1'b0 || state_dbg !== RF_INIT) begin
            errors++;
            $display("FAIL rst_run_async: ready=%b state=%0d expected 0/RF_INIT", ready, state_dbg);
        end
        tick();
        rst = 0;
        idle_inputs();
        for (int i = 1; i <= 9; i++) tick();
        #2;
        rst = 1;
        m_run = 1'b0; m_cnt = 1; m_pend = '0;
        #1;
        checks++;
        if (ready !== 1'b0 || state_dbg !== RF_INIT || read_busy !== 2'b11) begin
            errors++;
            $display("FAIL rst_sweep_async: ready=%b state=%0d busy=%b expected 0/RF_INIT/11",
                     ready, state_dbg, read_busy);
        end
        tick();
        rst = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (ready !== (i == 31)) begin
                errors++;
                $display("FAIL rst_restart edge %0d: ready=%b expected %b", i, ready, (i == 31));
            end
        end
        drive_reads(9, 0);
        sb_pop("r9_discarded");
    endtask

    task automatic test_random();
        logic [D-1:0] a0, a1;
        for (int n = 0; n < 200; n++) begin
            wr             = ($urandom_range(0, 1) == 1);
            write_register = D'($urandom_range(0, NR - 1));
            write_data     = W'($urandom());
            issue          = ($urandom_range(0, 2) == 0);
            issue_register = D'($urandom_range(0, NR - 1));
            a0 = D'($urandom_range(0, NR - 1));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : D'($urandom_range(0, NR - 1));
            drive_reads(a0, a1);
            sb_pop("random_data");
            checks++;
            if (read_busy !== {exp_busy(a1), exp_busy(a0)}) begin
                errors++;
                $display("FAIL random_busy iter %0d: got %b expected %b", n, read_busy,
                         {exp_busy(a1), exp_busy(a0)});
            end
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bypass();
        test_r0();
        test_busy();
        test_init_req();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
